prod_accumulator: RTL and testbench
===================================

# prod_accumulator

Accumulates the stream of 64-bit unsigned products from the pipelined 32x32 multiplier into dot-product sums. Each sum is requantized with a rounding right-shift and unsigned saturation, then buffered in a small output FIFO behind a valid/ready handshake. The multiplier has no backpressure, so this block accepts a product every cycle and never stalls its input.

## Interface
- ACC_W, 72: accumulator width; must be at least PROD_W.
- PROD_W, 64: input product width.
- OUT_W, 32: requantized result width.
- DEPTH, 4: output FIFO entries; must be a power of two and at least 2.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_prod is a valid product this cycle.
- in_prod  in  PROD_W  unsigned product.
- in_last  in  1  final product of the current group; qualified by in_valid.
- shift_amt  in  6  right-shift for requantization; latched on the first beat of each group.
- out_valid  out  1  FIFO not empty.
- out_data  out  OUT_W  requantized sum at the FIFO head.
- out_sat  out  1  head entry saturated, either in the accumulator or at requant.
- out_ready  in  1  consumer accepts the head.
- fifo_level  out  log2(DEPTH)+1  number of occupied entries.
- drop_err  out  1  sticky: a result was lost because the FIFO was full.
- clear_err  in  1  clears drop_err.

## Operation
- FSM states:
  - IDLE: no partial sum held.
  - ACCUM: a partial sum is held.
- Beat in IDLE, in_last=0:
  - acc <= in_prod, zero-extended.
  - shift_q <= shift_amt; sat_q <= 0.
  - Go to ACCUM.
- Beat in ACCUM, in_last=0:
  - acc <= acc + in_prod.
  - If the add carries out of ACC_W: acc <= all-ones, sat_q <= 1.
- Beat with in_last=1, either state:
  - sum is in_prod (IDLE) or acc + in_prod (ACCUM), using the same saturation rule.
  - The shift is shift_amt if the group started in IDLE this beat, otherwise shift_q.
  - The requant result is pushed into the FIFO; the FSM returns to IDLE.
- Requant:
  - r = (sum + (s==0 ? 0 : 1<<(s-1))) >> s, computed in ACC_W+1 bits (round half up).
  - If r > 2^OUT_W-1: out_data = 2^OUT_W-1 and the saturation flag is set.
  - Stored flag = sat_q OR accumulator saturation on this beat OR requant saturation.
- Beats with in_valid=0 leave all accumulator state unchanged; bubbles inside a group are legal.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push when a result completes.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
  - Push while full with no pop: the result is dropped and drop_err <= 1.
  - Pop while empty: no effect.
  - Read and write pointers wrap modulo DEPTH.
- drop_err:
  - clear_err has priority unless a drop occurs in the same cycle; the set wins.
- Reset:
  - state=IDLE, acc=0, FIFO emptied, drop_err=0.
  - A group in progress at reset is discarded.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, fifo_level=0, drop_err=0.
- Latency: a last beat sampled on edge t drives out_valid=1 with that data from cycle t+1, provided the FIFO was empty.
- Throughput: one product per cycle, sustained indefinitely. Single-beat groups (in_last on the first beat) can complete every cycle.
- out_data and out_sat come from FIFO storage and hold stable while out_valid=1 and out_ready=0.
- Critical path: ACC_W adder → rounding adder → barrel shifter → FIFO write.

## Structure
- Package tinyml_acc_pkg:
  - Width constants PROD_W, ACC_W, OUT_W.
  - enum acc_state_t {IDLE, ACCUM}.
  - Function requant(sum, shift) returning {sat, data}.
- Sub-module sync_fifo:
  - Parameterized width (OUT_W+1) and DEPTH.
  - Ports: push, pop, full, empty, level.
  - Reused by later stages.
- Top level: FSM, accumulator, requant, drop/error logic.

## Test plan
- Group 3, 5, 7 (last on 7), shift=1 → out_data=8 (15 rounded), out_sat=0, out_valid one cycle after the last beat.
- Single-beat group: in_prod=0x1_0000_0000, shift=0 → out_data=0xFFFFFFFF, out_sat=1. Same product with shift=4 → 0x10000000, out_sat=0.
- out_ready=0, five single-beat groups with DEPTH=4:
  - fifo_level=4 and drop_err=1.
  - Drain yields the first four values in order.
  - clear_err → drop_err=0.
- FIFO full, pop and push in the same cycle → level stays 4, no drop, ordering preserved.
- Long group: 257 beats of 0xFFFF_FFFF_FFFF_FFFF at ACC_W=72 → accumulator saturates; output out_sat=1, out_data=0xFFFFFFFF.
- Mixed bubbles and reset:
  - Group 10, bubble, 20, last 30, with shift_amt changed mid-group → result uses the first-beat shift.
  - rst asserted mid-group → no output; next group starts clean.

Source files
------------

// File: rtl/prod_accumulator_pkg.sv
// Shared widths, FSM state type and the requantization helper for the
// product accumulator and the stages built around it.
package tinyml_acc_pkg;

   localparam int PROD_W  = 64;
   localparam int ACC_W   = 72;
   localparam int OUT_W   = 32;
   localparam int SHIFT_W = 6;

   typedef enum logic {
      IDLE,
      ACCUM
   } acc_state_t;

   // Rounding right-shift (round half up) followed by unsigned saturation to
   // OUT_W bits. The extra top bit keeps the rounding carry from wrapping.
   // Result is {saturated, data}.
   function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0]   sum,
                                              input logic [SHIFT_W-1:0] shift);
      logic [ACC_W:0] bias;
      logic [ACC_W:0] r;
      logic [OUT_W:0] result;
      bias = '0;
      if (shift != '0) begin
         bias = {{ACC_W{1'b0}}, 1'b1} << (shift - 1'b1);
      end
      r = ({1'b0, sum} + bias) >> shift;
      if (r > {{(ACC_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}}) begin
         result = {1'b1, {OUT_W{1'b1}}};
      end else begin
         result = {1'b0, r[OUT_W-1:0]};
      end
      return result;
   endfunction

endpackage

// File: rtl/prod_accumulator_if.sv
// Product stream in, requantized result stream out.
interface prod_accumulator_if;
   import tinyml_acc_pkg::*;

   logic               in_valid;
   logic [PROD_W-1:0]  in_prod;
   logic               in_last;
   logic [SHIFT_W-1:0] shift_amt;
   logic               out_valid;
   logic [OUT_W-1:0]   out_data;
   logic               out_sat;
   logic               out_ready;

   // Producer/consumer side
   modport master (
      output in_valid, in_prod, in_last, shift_amt, out_ready,
      input  out_valid, out_data, out_sat
   );

   // Accumulator side
   modport slave (
      input  in_valid, in_prod, in_last, shift_amt, out_ready,
      output out_valid, out_data, out_sat
   );

endinterface

// File: rtl/prod_accumulator_fifo.sv
// Small synchronous FIFO; a push into a full FIFO only lands when a pop
// frees the head slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_W'(DEPTH));
   assign level   = level_q;
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // Advance pointers and occupancy; pointers wrap naturally at DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // Pointer and level registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/prod_accumulator.sv
// Sums grouped multiplier products, requantizes each finished sum and queues
// it for the consumer. Never backpressures the multiplier: a result that
// finds the FIFO full is dropped and flagged in drop_err.
module prod_accumulator
   import tinyml_acc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   prod_accumulator_if.slave      bus,
   input  logic                   clear_err,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   drop_err
);

   acc_state_t         state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic               sat_q, sat_d;
   logic               drop_err_q, drop_err_d;

   logic [ACC_W-1:0]   addend;
   logic [ACC_W:0]     ext_sum;
   logic               acc_carry;
   logic [ACC_W-1:0]   sum_sat;
   logic [SHIFT_W-1:0] grp_shift;
   logic               grp_sat;
   logic [OUT_W:0]     rq;
   logic [OUT_W:0]     push_data;
   logic [OUT_W:0]     head_data;
   logic               push, pop, full, empty, drop;

   // Datapath: add beat to running sum, saturate on carry, requantize
   always_comb begin
      addend    = (state_q == ACCUM) ? acc_q : '0;
      ext_sum   = {1'b0, addend} + {{(ACC_W+1-PROD_W){1'b0}}, bus.in_prod};
      acc_carry = ext_sum[ACC_W];
      sum_sat   = acc_carry ? {ACC_W{1'b1}} : ext_sum[ACC_W-1:0];
      grp_shift = (state_q == IDLE) ? bus.shift_amt : shift_q;
      grp_sat   = (state_q == ACCUM) && sat_q;
      rq        = requant(sum_sat, grp_shift);
      push      = bus.in_valid && bus.in_last;
      push_data = {grp_sat | acc_carry | rq[OUT_W], rq[OUT_W-1:0]};
      pop       = !empty && bus.out_ready;
      drop      = push && full && !pop;
   end

   // Next-state: a non-last beat opens a group, a last beat closes it
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid && !bus.in_last) state_d = ACCUM;
         ACCUM:   if (bus.in_valid &&  bus.in_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Accumulator, group shift/saturation and sticky drop flag updates
   always_comb begin
      acc_d      = acc_q;
      shift_d    = shift_q;
      sat_d      = sat_q;
      drop_err_d = drop_err_q;
      if (bus.in_valid) begin
         if (bus.in_last) begin
            acc_d = '0;
            sat_d = 1'b0;
         end else begin
            acc_d   = sum_sat;
            sat_d   = grp_sat | acc_carry;
            shift_d = grp_shift;
         end
      end
      if (drop) begin
         drop_err_d = 1'b1;
      end else if (clear_err) begin
         drop_err_d = 1'b0;
      end
   end

   // State register; reset discards any group in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         shift_q    <= '0;
         sat_q      <= 1'b0;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         shift_q    <= shift_d;
         sat_q      <= sat_d;
         drop_err_q <= drop_err_d;
      end
   end

   sync_fifo #(
      .WIDTH (OUT_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (push_data),
      .rd_data (head_data),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   assign bus.out_valid = !empty;
   assign bus.out_data  = head_data[OUT_W-1:0];
   assign bus.out_sat   = head_data[OUT_W];
   assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator with a group-level reference model.
module tb_prod_accumulator;
   import tinyml_acc_pkg::*;

   localparam int DEPTH = 4;

   typedef logic [79:0] wide_t;
   localparam wide_t ACC_LIMIT = wide_t'(1) << 72;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear_err;
   logic [2:0] fifo_level;
   logic       drop_err;

   int checks   = 0;
   int passes   = 0;
   bit checking = 1'b0;

   wide_t       m_sum;
   bit          m_in_group;
   bit          m_grp_sat;
   int          m_shift;
   bit          m_drop_err;
   logic [32:0] m_q[$];

   prod_accumulator_if bus ();

   prod_accumulator #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .clear_err  (clear_err),
      .fifo_level (fifo_level),
      .drop_err   (drop_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [63:0] prod, input logic last, input logic [5:0] sh);
      bus.in_valid  = v;
      bus.in_prod   = prod;
      bus.in_last   = last;
      bus.shift_amt = sh;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'd0, 1'b0, 6'd0);
   endtask

   // Round half up, divide by 2^s, clamp to 32 bits
   function automatic logic [32:0] model_requant(input wide_t sum, input int s, input bit sat_in);
      wide_t half;
      wide_t r;
      half = (s == 0) ? wide_t'(0) : (wide_t'(1) << (s - 1));
      r    = (sum + half) / (wide_t'(1) << s);
      if (r > wide_t'(64'hFFFF_FFFF)) return {1'b1, 32'hFFFF_FFFF};
      return {sat_in, r[31:0]};
   endfunction

   // Reference model: whole-group arithmetic plus a queue for the FIFO
   initial begin
      bit          do_pop;
      bit          do_push;
      bit          drop;
      logic [32:0] res;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_in_group = 1'b0;
            m_grp_sat  = 1'b0;
            m_sum      = '0;
            m_drop_err = 1'b0;
            m_q.delete();
         end else begin
            do_pop  = (m_q.size() > 0) && bus.out_ready;
            do_push = 1'b0;
            res     = '0;
            if (bus.in_valid) begin
               if (!m_in_group) begin
                  m_sum     = wide_t'(bus.in_prod);
                  m_shift   = int'(bus.shift_amt);
                  m_grp_sat = 1'b0;
               end else begin
                  m_sum = m_sum + wide_t'(bus.in_prod);
                  if (m_sum >= ACC_LIMIT) begin
                     m_sum     = ACC_LIMIT - 1;
                     m_grp_sat = 1'b1;
                  end
               end
               if (bus.in_last) begin
                  res        = model_requant(m_sum, m_shift, m_grp_sat);
                  do_push    = 1'b1;
                  m_in_group = 1'b0;
               end else begin
                  m_in_group = 1'b1;
               end
            end
            drop = do_push && (m_q.size() == DEPTH) && !do_pop;
            if (do_pop) void'(m_q.pop_front());
            if (do_push && !drop) m_q.push_back(res);
            if (drop) m_drop_err = 1'b1;
            else if (clear_err) m_drop_err = 1'b0;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (checking) begin
            checkOutput("fifo_level", 64'(fifo_level), 64'(m_q.size()));
            checkOutput("out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
            checkOutput("drop_err", 64'(drop_err), 64'(m_drop_err));
            if (m_q.size() > 0) begin
               checkOutput("out_data", 64'(bus.out_data), 64'(m_q[0][31:0]));
               checkOutput("out_sat", 64'(bus.out_sat), 64'(m_q[0][32]));
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      clear_err     = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_prod   = '0;
      bus.in_last   = 1'b0;
      bus.shift_amt = '0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      checking = 1'b1;
      checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset_out_data", 64'(bus.out_data), 64'd0);
      checkOutput("reset_out_sat", 64'(bus.out_sat), 64'd0);
      checkOutput("reset_fifo_level", 64'(fifo_level), 64'd0);
      checkOutput("reset_drop_err", 64'(drop_err), 64'd0);

      $display("[TB] group 3,5,7 shift 1");
      applyStimulus(1'b1, 64'd3, 1'b0, 6'd1);
      applyStimulus(1'b1, 64'd5, 1'b0, 6'd1);
      applyStimulus(1'b1, 64'd7, 1'b1, 6'd1);
      checkOutput("sum15_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("sum15_data", 64'(bus.out_data), 64'd8);
      checkOutput("sum15_sat", 64'(bus.out_sat), 64'd0);
      idle(1);

      $display("[TB] single-beat requant saturation");
      applyStimulus(1'b1, 64'h1_0000_0000, 1'b1, 6'd0);
      checkOutput("rq_sat_data", 64'(bus.out_data), 64'hFFFF_FFFF);
      checkOutput("rq_sat_flag", 64'(bus.out_sat), 64'd1);
      applyStimulus(1'b1, 64'h1_0000_0000, 1'b1, 6'd4);
      checkOutput("rq_shift4_data", 64'(bus.out_data), 64'h1000_0000);
      checkOutput("rq_shift4_sat", 64'(bus.out_sat), 64'd0);
      idle(2);

      $display("[TB] overflow with consumer stalled");
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 64'(i), 1'b1, 6'd0);
      checkOutput("ovf_level", 64'(fifo_level), 64'd4);
      checkOutput("ovf_drop_err", 64'(drop_err), 64'd1);
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checkOutput("drain_order", 64'(bus.out_data), 64'(i));
         idle(1);
      end
      checkOutput("drain_empty", 64'(bus.out_valid), 64'd0);
      clear_err = 1'b1;
      idle(1);
      clear_err = 1'b0;
      checkOutput("clear_err", 64'(drop_err), 64'd0);

      $display("[TB] push and pop while full");
      bus.out_ready = 1'b0;
      for (int i = 11; i <= 14; i++) applyStimulus(1'b1, 64'(i), 1'b1, 6'd0);
      bus.out_ready = 1'b1;
      applyStimulus(1'b1, 64'd15, 1'b1, 6'd0);
      checkOutput("full_pp_level", 64'(fifo_level), 64'd4);
      checkOutput("full_pp_drop", 64'(drop_err), 64'd0);
      for (int i = 12; i <= 15; i++) begin
         checkOutput("full_pp_order", 64'(bus.out_data), 64'(i));
         idle(1);
      end

      $display("[TB] 257-beat accumulator saturation");
      for (int i = 0; i < 257; i++) applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, (i == 256), 6'd0);
      checkOutput("long_data", 64'(bus.out_data), 64'hFFFF_FFFF);
      checkOutput("long_sat", 64'(bus.out_sat), 64'd1);
      idle(1);

      $display("[TB] bubbles and mid-group shift change");
      applyStimulus(1'b1, 64'd10, 1'b0, 6'd2);
      applyStimulus(1'b0, 64'd0, 1'b0, 6'd5);
      applyStimulus(1'b1, 64'd20, 1'b0, 6'd5);
      applyStimulus(1'b1, 64'd30, 1'b1, 6'd7);
      checkOutput("bubble_data", 64'(bus.out_data), 64'd15);
      checkOutput("bubble_sat", 64'(bus.out_sat), 64'd0);
      idle(1);

      $display("[TB] reset mid-group");
      applyStimulus(1'b1, 64'd100, 1'b0, 6'd0);
      applyStimulus(1'b1, 64'd200, 1'b0, 6'd0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      checkOutput("rst_mid_valid", 64'(bus.out_valid), 64'd0);
      applyStimulus(1'b1, 64'd7, 1'b1, 6'd0);
      checkOutput("rst_clean_data", 64'(bus.out_data), 64'd7);
      checkOutput("rst_clean_sat", 64'(bus.out_sat), 64'd0);
      idle(2);

      checking = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
